dallanma_guncelleme_denetleyici: RTL
====================================

Name: dallanma_guncelleme_denetleyici

Overview:
Sequences updates into the branch predictor (dallanma_ongorucu) and owns misprediction recovery.
- Buffers resolved-branch reports from the execute stage in a small FIFO.
- Arbitrates the predictor's single table port between fetch-side lookups and queued updates, with a starvation guard.
- On a misprediction, runs a flush/redirect FSM toward fetch.

Parameters:
KUYRUK_DERINLIK, 4, update FIFO depth; power of two, at least 2.
ACLIK_SINIRI, 3, consecutive cycles a non-empty queue may lose arbitration before forcing a write.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-low
ddb_durdur_i  in  1  pipeline stall; freezes FSM and arbitration, FIFO contents held
yrt_gecerli_i  in  1  resolved branch report valid
yrt_ps_i  in  18  branch PC [18:1]
yrt_atlanan_ps_i  in  18  actual target [18:1]
yrt_atladi_i  in  1  branch actually taken
yrt_hata_i  in  1  prediction was wrong
yrt_ctipi_i  in  1  branch is compressed (2-byte)
yrt_hazir_o  out  1  FIFO can accept a report
tahmin_et_i  in  1  fetch requests a predictor lookup this cycle
tahmin_engel_o  out  1  lookup blocked this cycle (forced update)
gnc_gecerli_o  out  1  predictor table write strobe
gnc_ps_o  out  18  write PC
gnc_atlanan_ps_o  out  18  write target
gnc_atladi_o  out  1  write outcome
bosalt_o  out  1  flush fetch/decode
duzeltme_ps_o  out  18  redirect PC, valid while bosalt_o=1

Behaviour:
- Reset (rst_i=0, async):
  - FIFO empty; FSM in BOSTA; starvation counter 0.
  - Outputs: yrt_hazir_o=0, tahmin_engel_o=0, gnc_gecerli_o=0, bosalt_o=0, gnc_*/duzeltme_ps_o=0.
  - yrt_hazir_o goes to 1 on the first clock after release.
- Enqueue:
  - A report is pushed when yrt_gecerli_i & yrt_hazir_o & !ddb_durdur_i.
  - Reports arriving while yrt_hazir_o=0 are dropped; this is legal and is not an error.
  - yrt_hazir_o = !full & (state != SUZ).
- Arbitration, evaluated each non-stalled cycle with the FIFO non-empty:
  - If !tahmin_et_i: pop the head, gnc_gecerli_o=1 registered (1-cycle latency), counter cleared.
  - If tahmin_et_i and counter < ACLIK_SINIRI: lookup wins, counter increments.
  - If tahmin_et_i and counter == ACLIK_SINIRI: tahmin_engel_o=1 combinationally, pop the head, counter cleared.
- Empty FIFO: no write; counter held at 0.
- Simultaneous push and pop on a full FIFO: the pop occurs, the push is refused (hazir was 0).
- Simultaneous push and pop on an empty FIFO: no bypass; the entry is written on a later cycle.
- Pointers wrap modulo KUYRUK_DERINLIK; an extra MSB distinguishes full from empty.
- FSM (ddb_durdur_i freezes all transitions):
  - BOSTA:
    - On an accepted report with yrt_hata_i=1, go to BOSALT.
    - Capture duzeltme_ps_o = yrt_atlanan_ps_i if taken.
    - Otherwise capture yrt_ps_i+1 (compressed) or yrt_ps_i+2 (non-compressed), in [18:1] units; the sum wraps mod 2^18.
  - BOSALT: bosalt_o=1 for exactly one cycle, then go to SUZ.
  - SUZ: intake is blocked; lookups are ignored for arbitration, so every non-stalled cycle pops. Return to BOSTA the cycle after the FIFO empties.
  - A mispredict report arriving while not in BOSTA is still enqueued if accepted, but does not re-trigger the FSM (an older flush dominates).
- Mid-operation reset: all state cleared immediately, including a pending bosalt_o and gnc_gecerli_o.

Optional Feature:
DALLANMA_SAYAC_EN
- Defined:
  - Adds 32-bit saturating counters hata_sayisi_o (accepted mispredict reports) and guncelleme_sayisi_o (pops).
  - Adds input sayac_sifirla_i to clear both counters synchronously.
  - Counters reset to 0 on rst_i.
- Undefined: the ports and logic are absent; the core behaviour is identical.

Decomposition:
- Shared package/header (tanimlamalar.vh):
  - state encodings BOSTA=2'd0, BOSALT=2'd1, SUZ=2'd2;
  - PS width constant (18);
  - the packed update-entry layout {ps, atlanan_ps, atladi} = 37 bits.
- One sub-module, guncelleme_kuyrugu: a synchronous FIFO with push/pop/full/empty, parameterised depth and width.
- Arbitration and FSM stay in the top-level module.

Test Plan:
1. Reset then idle: after release, yrt_hazir_o=1 and all other outputs 0; gnc_gecerli_o never asserts.
2. Push {ps=0x00FC0, target=0x00FE0, taken=1}, tahmin_et_i=0 → next cycle gnc_gecerli_o=1 with the same fields; FIFO empty.
3. Hold tahmin_et_i=1 with one entry queued → no write for 3 cycles; 4th cycle tahmin_engel_o=1 and a write the next cycle.
4. Push 4 reports with tahmin_et_i=1 → yrt_hazir_o=0; a 5th report is dropped; only 4 writes observed after release.
5. Mispredict, non-taken, compressed, ps=0x00100 → bosalt_o=1 for one cycle with duzeltme_ps_o=0x00101; yrt_hazir_o low until the FIFO drains.
6. ddb_durdur_i=1 during BOSALT, then reset asserted mid-SUZ → bosalt_o held while stalled; reset immediately zeroes all outputs and empties the FIFO.

Source files
------------

// File: rtl/dallanma_guncelleme_denetleyici_pkg.sv
// Shared definitions for the branch predictor update controller: FSM encodings,
// PC width and the packed update-entry layout.
package dallanma_guncelleme_denetleyici_pkg;

   localparam int unsigned PS_W = 18;

   localparam logic [1:0] BOSTA  = 2'd0;
   localparam logic [1:0] BOSALT = 2'd1;
   localparam logic [1:0] SUZ    = 2'd2;

   typedef struct packed {
      logic [PS_W-1:0] ps;
      logic [PS_W-1:0] atlanan_ps;
      logic            atladi;
   } guncelleme_girdi_t;

   localparam int unsigned GIRDI_W = $bits(guncelleme_girdi_t);

   // PCs are in halfword units, so the fall-through step is 1 (compressed) or 2.
   function automatic logic [PS_W-1:0] duzeltme_hesapla(input logic [PS_W-1:0] ps,
                                                        input logic [PS_W-1:0] hedef,
                                                        input logic            atladi,
                                                        input logic            ctipi);
      if (atladi) begin
         return hedef;
      end else if (ctipi) begin
         return ps + PS_W'(1);
      end else begin
         return ps + PS_W'(2);
      end
   endfunction

endpackage

// File: rtl/dallanma_guncelleme_denetleyici_guncelleme_kuyrugu.sv
// Synchronous FIFO for resolved-branch update entries; pointers carry an extra
// MSB so full and empty are distinguishable. Depth must be a power of two.
module dallanma_guncelleme_denetleyici_guncelleme_kuyrugu #(
   parameter int unsigned DERINLIK = 4,
   parameter int unsigned GENISLIK = 37
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                yaz,
   input  logic                oku,
   input  logic [GENISLIK-1:0] yaz_veri,
   output logic [GENISLIK-1:0] bas_veri,
   output logic                dolu,
   output logic                bos
);

   localparam int unsigned AW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
   localparam logic [AW:0] BIR = (AW + 1)'(1);

   logic [AW:0]         yaz_ptr_q;
   logic [AW:0]         oku_ptr_q;
   logic [GENISLIK-1:0] bellek_q [DERINLIK];

   assign bos      = (yaz_ptr_q == oku_ptr_q);
   assign dolu     = (yaz_ptr_q[AW] != oku_ptr_q[AW]) &&
                     (yaz_ptr_q[AW-1:0] == oku_ptr_q[AW-1:0]);
   assign bas_veri = bellek_q[oku_ptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         yaz_ptr_q <= '0;
         oku_ptr_q <= '0;
      end else begin
         if (yaz && !dolu) begin
            yaz_ptr_q <= yaz_ptr_q + BIR;
         end
         if (oku && !bos) begin
            oku_ptr_q <= oku_ptr_q + BIR;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (yaz && !dolu) begin
         bellek_q[yaz_ptr_q[AW-1:0]] <= yaz_veri;
      end
   end

endmodule

// File: rtl/dallanma_guncelleme_denetleyici.sv
// Branch predictor update sequencer and misprediction flush/redirect FSM.
// Optional statistics counters are enabled with DALLANMA_SAYAC_EN.
module dallanma_guncelleme_denetleyici
   import dallanma_guncelleme_denetleyici_pkg::*;
#(
   parameter int unsigned KUYRUK_DERINLIK = 4,
   parameter int unsigned ACLIK_SINIRI    = 3
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            ddb_durdur_i,
   input  logic            yrt_gecerli_i,
   input  logic [PS_W-1:0] yrt_ps_i,
   input  logic [PS_W-1:0] yrt_atlanan_ps_i,
   input  logic            yrt_atladi_i,
   input  logic            yrt_hata_i,
   input  logic            yrt_ctipi_i,
   output logic            yrt_hazir_o,
   input  logic            tahmin_et_i,
   output logic            tahmin_engel_o,
   output logic            gnc_gecerli_o,
   output logic [PS_W-1:0] gnc_ps_o,
   output logic [PS_W-1:0] gnc_atlanan_ps_o,
   output logic            gnc_atladi_o,
   output logic            bosalt_o,
`ifdef DALLANMA_SAYAC_EN
   input  logic            sayac_sifirla_i,
   output logic [31:0]     hata_sayisi_o,
   output logic [31:0]     guncelleme_sayisi_o,
`endif
   output logic [PS_W-1:0] duzeltme_ps_o
);

   localparam int unsigned SW = (ACLIK_SINIRI > 0) ? $clog2(ACLIK_SINIRI + 1) : 1;
   localparam logic [SW-1:0] ACLIK_MAX = SW'(ACLIK_SINIRI);

   logic              acik_q;
   logic [1:0]        durum_q, durum_d;
   logic [SW-1:0]     aclik_q, aclik_d;
   logic [PS_W-1:0]   duzeltme_q, duzeltme_d;
   logic              gnc_gecerli_q;
   guncelleme_girdi_t gnc_q;

   logic              kuyruk_dolu, kuyruk_bos;
   logic              yaz, oku, zorla;
   guncelleme_girdi_t giris, bas;

   assign giris = '{ps: yrt_ps_i, atlanan_ps: yrt_atlanan_ps_i, atladi: yrt_atladi_i};

   // acik_q holds intake closed until the first clock after reset release.
   assign yrt_hazir_o = acik_q && !kuyruk_dolu && (durum_q != SUZ);
   assign yaz         = yrt_gecerli_i && yrt_hazir_o && !ddb_durdur_i;

   dallanma_guncelleme_denetleyici_guncelleme_kuyrugu #(
      .DERINLIK (KUYRUK_DERINLIK),
      .GENISLIK (GIRDI_W)
   ) u_kuyruk (
      .clk      (clk_i),
      .rst_n    (rst_i),
      .yaz      (yaz),
      .oku      (oku),
      .yaz_veri (giris),
      .bas_veri (bas),
      .dolu     (kuyruk_dolu),
      .bos      (kuyruk_bos)
   );

   // Table-port arbitration; during SUZ the queue drains regardless of lookups.
   always_comb begin
      oku     = 1'b0;
      zorla   = 1'b0;
      aclik_d = aclik_q;
      if (!ddb_durdur_i) begin
         if (kuyruk_bos) begin
            aclik_d = '0;
         end else if ((durum_q == SUZ) || !tahmin_et_i) begin
            oku     = 1'b1;
            aclik_d = '0;
         end else if (aclik_q == ACLIK_MAX) begin
            zorla   = 1'b1;
            oku     = 1'b1;
            aclik_d = '0;
         end else begin
            aclik_d = aclik_q + SW'(1);
         end
      end
   end

   assign tahmin_engel_o = zorla;

   always_comb begin
      durum_d    = durum_q;
      duzeltme_d = duzeltme_q;
      if (!ddb_durdur_i) begin
         case (durum_q)
            BOSTA: begin
               if (yaz && yrt_hata_i) begin
                  durum_d    = BOSALT;
                  duzeltme_d = duzeltme_hesapla(yrt_ps_i, yrt_atlanan_ps_i,
                                                yrt_atladi_i, yrt_ctipi_i);
               end
            end
            BOSALT:  durum_d = SUZ;
            SUZ: begin
               if (kuyruk_bos) begin
                  durum_d = BOSTA;
               end
            end
            default: durum_d = BOSTA;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         acik_q        <= 1'b0;
         durum_q       <= BOSTA;
         aclik_q       <= '0;
         duzeltme_q    <= '0;
         gnc_gecerli_q <= 1'b0;
         gnc_q         <= '0;
      end else begin
         acik_q        <= 1'b1;
         durum_q       <= durum_d;
         aclik_q       <= aclik_d;
         duzeltme_q    <= duzeltme_d;
         gnc_gecerli_q <= oku;
         if (oku) begin
            gnc_q <= bas;
         end
      end
   end

   assign gnc_gecerli_o    = gnc_gecerli_q;
   assign gnc_ps_o         = gnc_q.ps;
   assign gnc_atlanan_ps_o = gnc_q.atlanan_ps;
   assign gnc_atladi_o     = gnc_q.atladi;
   assign bosalt_o         = (durum_q == BOSALT);
   assign duzeltme_ps_o    = duzeltme_q;

`ifdef DALLANMA_SAYAC_EN
   logic [31:0] hata_sayac_q;
   logic [31:0] gnc_sayac_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         hata_sayac_q <= '0;
         gnc_sayac_q  <= '0;
      end else if (sayac_sifirla_i) begin
         hata_sayac_q <= '0;
         gnc_sayac_q  <= '0;
      end else begin
         if (yaz && yrt_hata_i && (hata_sayac_q != '1)) begin
            hata_sayac_q <= hata_sayac_q + 32'd1;
         end
         if (oku && (gnc_sayac_q != '1)) begin
            gnc_sayac_q <= gnc_sayac_q + 32'd1;
         end
      end
   end

   assign hata_sayisi_o       = hata_sayac_q;
   assign guncelleme_sayisi_o = gnc_sayac_q;
`endif

endmodule
